// File: rtl/alu_result_collect.sv
// Collects per-lane ALU results into a captured PHV and presents the merged
// container vector once every issued lane has reported back.
module alu_result_collect #(
   parameter int NUM_ALU    = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_ALU*DATA_WIDTH-1:0] phv_in,
   input  logic [NUM_ALU-1:0]            alu_mask_in,
   input  logic                          phv_in_valid,
   output logic                          phv_in_ready,
   input  logic [NUM_ALU*DATA_WIDTH-1:0] alu_container_in,
   input  logic [NUM_ALU-1:0]            alu_container_valid,
   output logic [NUM_ALU-1:0]            alu_ready_out,
   output logic [NUM_ALU*DATA_WIDTH-1:0] phv_out,
   output logic                          phv_out_valid,
   input  logic                          phv_out_ready,
   output logic                          err_unexpected,
   output logic [7:0]                    err_cnt
);

   localparam int W = NUM_ALU * DATA_WIDTH;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      OUTPUT
   } state_t;

   state_t             state_q, state_d;
   logic [NUM_ALU-1:0] done_q, done_d;
   logic [W-1:0]       slot_q, slot_d;
   logic [NUM_ALU-1:0] take;
   logic [NUM_ALU-1:0] stray;
   logic               err_q;
   logic [7:0]         cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         done_q  <= '0;
         slot_q  <= '0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
         slot_q  <= slot_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      done_d        = done_q;
      slot_d        = slot_q;
      take          = '0;
      stray         = '0;
      phv_in_ready  = 1'b0;
      alu_ready_out = '0;
      phv_out_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            phv_in_ready = 1'b1;
            stray        = alu_container_valid;
            if (phv_in_valid) begin
               slot_d  = phv_in;
               done_d  = ~alu_mask_in;
               state_d = (alu_mask_in == '0) ? OUTPUT : WAIT;
            end
         end
         WAIT: begin
            alu_ready_out = ~done_q;
            take          = alu_container_valid & ~done_q;
            stray         = alu_container_valid & done_q;
            for (int i = 0; i < NUM_ALU; i++) begin
               if (take[i])
                  slot_d[i*DATA_WIDTH +: DATA_WIDTH] =
                     alu_container_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
            done_d = done_q | take;
            if (&done_d)
               state_d = OUTPUT;
         end
         OUTPUT: begin
            phv_out_valid = 1'b1;
            stray         = alu_container_valid;
            if (phv_out_ready) begin
               done_d  = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // any number of stray lanes in one cycle is a single error event
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
         cnt_q <= '0;
      end else if (|stray) begin
         err_q <= 1'b1;
         if (cnt_q != 8'hFF)
            cnt_q <= cnt_q + 8'd1;
      end
   end

   assign phv_out        = slot_q;
   assign err_unexpected = err_q;
   assign err_cnt        = cnt_q;

endmodule

// File: tb/tb_alu_result_collect.sv
// Randomized and directed bench for alu_result_collect against a
// transaction-level model of the collector.
module tb_alu_result_collect;

   localparam int NA = 4;
   localparam int DW = 32;
   localparam int W  = NA * DW;

   logic          clk = 1'b0;
   logic          rst;
   logic [W-1:0]  phv_in;
   logic [NA-1:0] alu_mask_in;
   logic          phv_in_valid;
   logic          phv_in_ready;
   logic [W-1:0]  alu_container_in;
   logic [NA-1:0] alu_container_valid;
   logic [NA-1:0] alu_ready_out;
   logic [W-1:0]  phv_out;
   logic          phv_out_valid;
   logic          phv_out_ready;
   logic          err_unexpected;
   logic [7:0]    err_cnt;

   int checks = 0;
   int errors = 0;

   // model: a held PHV, the lanes still owed, and the error counters
   bit            m_have;
   logic [NA-1:0] m_pend;
   logic [DW-1:0] m_out [NA];
   bit            m_err;
   int            m_cnt;

   alu_result_collect #(.NUM_ALU(NA), .DATA_WIDTH(DW)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .phv_in              (phv_in),
      .alu_mask_in         (alu_mask_in),
      .phv_in_valid        (phv_in_valid),
      .phv_in_ready        (phv_in_ready),
      .alu_container_in    (alu_container_in),
      .alu_container_valid (alu_container_valid),
      .alu_ready_out       (alu_ready_out),
      .phv_out             (phv_out),
      .phv_out_valid       (phv_out_valid),
      .phv_out_ready       (phv_out_ready),
      .err_unexpected      (err_unexpected),
      .err_cnt             (err_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [W-1:0] act,
                      input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_have = 0;
      m_pend = '0;
      m_err  = 0;
      m_cnt  = 0;
      for (int i = 0; i < NA; i++) m_out[i] = '0;
   endtask

   task automatic model_step();
      logic [NA-1:0] bad;
      bad = '0;
      if (rst) begin
         model_reset();
      end else begin
         if (!m_have) begin
            bad = alu_container_valid;
            if (phv_in_valid) begin
               m_have = 1;
               m_pend = alu_mask_in;
               for (int i = 0; i < NA; i++) m_out[i] = phv_in[i*DW +: DW];
            end
         end else if (m_pend != '0) begin
            for (int i = 0; i < NA; i++) begin
               if (alu_container_valid[i]) begin
                  if (m_pend[i]) begin
                     m_out[i]  = alu_container_in[i*DW +: DW];
                     m_pend[i] = 1'b0;
                  end else begin
                     bad[i] = 1'b1;
                  end
               end
            end
         end else begin
            bad = alu_container_valid;
            if (phv_out_ready) m_have = 0;
         end
         if (bad != '0) begin
            m_err = 1;
            if (m_cnt < 255) m_cnt++;
         end
      end
   endtask

   task automatic check_all();
      logic [W-1:0] e;
      for (int i = 0; i < NA; i++) e[i*DW +: DW] = m_out[i];
      chk("phv_out", phv_out, e);
      chk("phv_out_valid", W'(phv_out_valid), W'(m_have && m_pend == '0));
      chk("phv_in_ready", W'(phv_in_ready), W'(!m_have));
      chk("alu_ready_out", W'(alu_ready_out), W'(m_have ? m_pend : '0));
      chk("err_unexpected", W'(err_unexpected), W'(m_err));
      chk("err_cnt", W'(err_cnt), W'(m_cnt));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
   endtask

   task automatic idle_in();
      phv_in_valid        = 0;
      alu_mask_in         = '0;
      phv_in              = '0;
      alu_container_valid = '0;
      alu_container_in    = '0;
      phv_out_ready       = 0;
   endtask

   task automatic do_reset();
      rst = 1;
      #1;
      model_reset();
      chk("rst_valid", W'(phv_out_valid), W'(0));
      chk("rst_in_ready", W'(phv_in_ready), W'(1));
      chk("rst_alu_ready", W'(alu_ready_out), W'(0));
      chk("rst_phv_out", phv_out, W'(0));
      chk("rst_err", W'({err_unexpected, err_cnt}), W'(0));
      tick();
      rst = 0;
   endtask

   initial begin
      rst = 1;
      idle_in();
      @(negedge clk);
      do_reset();

      // mixed mask: two lanes answer at different times
      phv_in_valid = 1;
      alu_mask_in  = 4'b0101;
      phv_in       = {32'h33, 32'h22, 32'h11, 32'h00};
      tick();
      idle_in();
      tick();
      alu_container_valid = 4'b0001;
      alu_container_in[31:0] = 32'hA0;
      tick();
      alu_container_valid = '0;
      tick();
      chk("r19_not_yet", W'(phv_out_valid), W'(0));
      chk("r19_ready", W'(alu_ready_out), W'(4'b0100));
      alu_container_valid = 4'b0100;
      alu_container_in[95:64] = 32'hC2;
      tick();
      chk("r19_valid", W'(phv_out_valid), W'(1));
      chk("r19_phv", phv_out, {32'h33, 32'hC2, 32'h11, 32'hA0});
      idle_in();
      phv_out_ready = 1;
      tick();
      chk("r19_back_idle", W'(phv_in_ready), W'(1));

      // all lanes in one cycle
      idle_in();
      phv_in_valid = 1;
      alu_mask_in  = 4'b1111;
      phv_in       = {4{32'hDEAD_BEEF}};
      tick();
      idle_in();
      alu_container_valid = 4'b1111;
      alu_container_in    = {32'd4, 32'd3, 32'd2, 32'd1};
      tick();
      chk("r20_phv", phv_out, {32'd4, 32'd3, 32'd2, 32'd1});
      chk("r20_alu_ready", W'(alu_ready_out), W'(0));
      chk("r20_valid", W'(phv_out_valid), W'(1));
      idle_in();
      phv_out_ready = 1;
      tick();

      // zero mask bypass and backpressure
      idle_in();
      phv_in_valid = 1;
      phv_in       = {32'h1234_5678, 32'h9ABC_DEF0, 32'h0BAD_F00D, 32'hCAFE_0001};
      tick();
      idle_in();
      phv_in_valid = 1;
      phv_in       = '1;
      for (int k = 0; k < 5; k++) begin
         chk("r21_valid", W'(phv_out_valid), W'(1));
         chk("r21_hold", phv_out,
             {32'h1234_5678, 32'h9ABC_DEF0, 32'h0BAD_F00D, 32'hCAFE_0001});
         chk("r21_in_ready", W'(phv_in_ready), W'(0));
         tick();
      end
      idle_in();
      phv_out_ready = 1;
      tick();
      idle_in();
      do_reset();

      // repeated pulse on a finished lane
      phv_in_valid = 1;
      alu_mask_in  = 4'b0011;
      phv_in       = '0;
      tick();
      idle_in();
      alu_container_valid = 4'b0010;
      alu_container_in[63:32] = 32'h55;
      tick();
      alu_container_in[63:32] = 32'hFF;
      tick();
      chk("r22_slot", W'(phv_out[63:32]), W'(32'h55));
      chk("r22_err", W'(err_unexpected), W'(1));
      chk("r22_cnt", W'(err_cnt), W'(1));
      alu_container_valid = 4'b0001;
      alu_container_in[31:0] = 32'h77;
      tick();
      chk("r22_out", phv_out, {32'h0, 32'h0, 32'h55, 32'h77});
      idle_in();
      phv_out_ready = 1;
      tick();
      idle_in();
      alu_container_valid = 4'b1001;
      for (int k = 0; k < 300; k++) tick();
      chk("r22_sat", W'(err_cnt), W'(255));

      // reset in the middle of a wait
      idle_in();
      phv_in_valid = 1;
      alu_mask_in  = 4'b0100;
      phv_in       = {4{32'hAAAA_5555}};
      tick();
      idle_in();
      alu_container_valid = 4'b0100;
      alu_container_in    = {4{32'h0F0F_0F0F}};
      do_reset();
      chk("r23_after_cnt", W'(err_cnt), W'(0));
      idle_in();
      phv_in_valid = 1;
      phv_in       = {32'h4, 32'h3, 32'h2, 32'h1};
      tick();
      chk("r23_valid", W'(phv_out_valid), W'(1));
      chk("r23_phv", phv_out, {32'h4, 32'h3, 32'h2, 32'h1});
      idle_in();
      phv_out_ready = 1;
      tick();

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         rst          = ($urandom_range(0, 499) == 0);
         phv_in_valid = $urandom_range(0, 1);
         alu_mask_in  = ($urandom_range(0, 3) == 0) ? '0 : NA'($urandom);
         for (int i = 0; i < NA; i++) begin
            phv_in[i*DW +: DW]           = $urandom;
            alu_container_in[i*DW +: DW] = $urandom;
            alu_container_valid[i]       = ($urandom_range(0, 9) < 3);
         end
         phv_out_ready = ($urandom_range(0, 9) < 6);
         tick();
      end
      rst = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_result_collect.md
ALU_RESULT_COLLECT -- requirements
Module: alu_result_collect

Interface
REQ-001 SHALL have parameter NUM_ALU, default 4: number of ALU lanes collected.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: width of one container.
REQ-003 SHALL have these ports, one clock; reset is asynchronous and active-high:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- phv_in  in  NUM_ALU*DATA_WIDTH  original containers, lane i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- alu_mask_in  in  NUM_ALU  bit i=1: lane i ALU issued an action for this PHV
- phv_in_valid  in  1  phv_in/alu_mask_in valid
- phv_in_ready  out  1  collector can accept a PHV
- alu_container_in  in  NUM_ALU*DATA_WIDTH  per-lane ALU container_out_w
- alu_container_valid  in  NUM_ALU  per-lane one-cycle result pulse
- alu_ready_out  out  NUM_ALU  per-lane ready_in to ALU
- phv_out  out  NUM_ALU*DATA_WIDTH  merged containers
- phv_out_valid  out  1  phv_out valid
- phv_out_ready  in  1  downstream accepts
- err_unexpected  out  1  sticky: ALU pulse not expected
- err_cnt  out  8  saturating count of unexpected pulses

Function
REQ-004 SHALL implement states IDLE, WAIT, OUTPUT, held in registers.
REQ-005 SHALL drive phv_in_ready=1 only in IDLE; alu_ready_out[i]=1 only in WAIT with done[i]=0; phv_out_valid=1 only in OUTPUT.
REQ-006 IDLE: phv_in_valid=1 captures phv_in into slot registers and sets done = ~alu_mask_in.
REQ-007 IDLE capture with alu_mask_in=0 SHALL go directly to OUTPUT, so phv_out_valid is high the cycle after capture, with phv_out = phv_in.
REQ-008 IDLE capture with alu_mask_in nonzero SHALL go to WAIT.
REQ-009 WAIT: alu_container_valid[i]=1 with done[i]=0 SHALL load slot i from alu_container_in lane i and set done[i]; multiple lanes in one cycle are all taken.
REQ-010 WAIT: when done OR accepted-pulses is all ones in a cycle, next state SHALL be OUTPUT; latency from last accepted pulse to phv_out_valid is 1 cycle.
REQ-011 OUTPUT: phv_out and phv_out_valid SHALL hold stable until phv_out_ready=1; on handshake, clear done, go to IDLE; no new PHV captured in that same cycle.
REQ-012 Unexpected pulse: alu_container_valid[i]=1 in IDLE, in OUTPUT, or in WAIT with done[i]=1 SHALL be discarded (slot unchanged), set err_unexpected, increment err_cnt saturating at 255; several unexpected lanes in one cycle count as one increment.
REQ-013 Unmasked lanes SHALL output the captured phv_in lane unchanged.
REQ-014 phv_out SHALL be driven directly from slot registers (no combinational path from alu_container_in).
REQ-015 Throughput SHALL be at most one PHV per 2 cycles (IDLE and OUTPUT each occupy at least one cycle).

Reset
REQ-016 rst=1 SHALL immediately and asynchronously force state=IDLE, done=0, slots=0, phv_out_valid=0, phv_in_ready=1, alu_ready_out=0, err_unexpected=0, err_cnt=0.
REQ-017 Reset mid-WAIT or mid-OUTPUT SHALL drop the in-flight PHV; pulses arriving while rst=1 are ignored and not counted.
REQ-018 err_unexpected and err_cnt SHALL be cleared only by reset.

Verification
REQ-019 NUM_ALU=4: mask=4'b0101, phv_in lanes {3:0x33,2:0x22,1:0x11,0:0x00}; lane0 pulse 0xA0 at T+2, lane2 pulse 0xC2 at T+4 -> phv_out_valid at T+5, phv_out={0x33,0xC2,0x11,0xA0}.
REQ-020 mask=4'b1111, all four lanes pulse in same cycle with 1,2,3,4 -> next cycle phv_out={4,3,2,1}, alu_ready_out=0.
REQ-021 mask=0 capture at T -> phv_out_valid=1 at T+1, phv_out=phv_in; phv_out_ready low 5 cycles -> output held, phv_in_ready=0 throughout.
REQ-022 Second pulse on already-done lane 1 in WAIT (value 0xFF) -> slot keeps first value, err_unexpected=1, err_cnt=1; 300 unexpected IDLE pulses -> err_cnt=255.
REQ-023 rst asserted during WAIT with lane 2 pending -> outputs at reset values same cycle; after release, new PHV with mask=0 outputs correctly at capture+1.
